// File: rtl/vxe_txnreqd_packer.sv
// vxe_txnreqd_packer: assembles narrow write-data beats (with byte enables)
// lane by lane into full-width request words and hands them to the request
// encoder through a small FIFO with a valid/ready handshake. A last-beat
// marker flushes a partially assembled word with zeroed unwritten lanes.
module vxe_txnreqd_packer #(
    parameter int DATA_W = 64,
    parameter int LANES  = 2,
    parameter int DEPTH  = 2
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           i_vld,
    output logic                           o_rdy,
    input  logic [DATA_W/LANES-1:0]        i_data,
    input  logic [DATA_W/LANES/8-1:0]      i_ben,
    input  logic                           i_last,
    output logic                           o_vld,
    input  logic                           i_rdy,
    output logic [DATA_W+DATA_W/8-1:0]     o_req_vec_dat,
    output logic                           o_busy
);

    localparam int IW   = DATA_W / LANES;
    localparam int BW   = IW / 8;
    localparam int NB   = DATA_W / 8;
    localparam int OW   = DATA_W + NB;
    localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW   = $clog2(DEPTH);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - 1);

    // Assembly state
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0] asm_dat_q, asm_dat_d;
    logic [NB-1:0]     asm_ben_q, asm_ben_d;

    // FIFO state
    logic [PW:0]       wr_ptr_q, wr_ptr_d;
    logic [PW:0]       rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]     mem_q [DEPTH];
    logic [OW-1:0]     mem_d [DEPTH];

    // Combinational helpers
    logic [DATA_W-1:0] merged_dat_s;
    logic [NB-1:0]     merged_ben_s;
    logic              full_s;
    logic              empty_s;
    logic              accept_s;
    logic              close_s;
    logic              push_s;
    logic              pop_s;

    // Full when the pointers differ only in the wrap bit; empty when equal.
    assign full_s   = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty_s  = (wr_ptr_q == rd_ptr_q);

    // Handshake outputs depend on registered pointers only.
    assign o_rdy    = !full_s;
    assign o_vld    = !empty_s;
    assign o_busy   = (idx_q != {IDXW{1'b0}}) || !empty_s;
    assign o_req_vec_dat = mem_q[rd_ptr_q[PW-1:0]];

    assign accept_s = i_vld && !full_s;
    assign close_s  = (idx_q == LAST_IDX) || i_last;
    assign push_s   = accept_s && close_s;
    assign pop_s    = !empty_s && i_rdy;

    // Overlay the incoming beat onto the lane selected by idx.
    always_comb begin
        merged_dat_s = asm_dat_q;
        merged_ben_s = asm_ben_q;
        for (int k = 0; k < LANES; k++) begin
            merged_dat_s[k*IW +: IW] = (idx_q == IDXW'(k)) ? i_data : asm_dat_q[k*IW +: IW];
            merged_ben_s[k*BW +: BW] = (idx_q == IDXW'(k)) ? i_ben  : asm_ben_q[k*BW +: BW];
        end
    end

    // Assembly next state: advance the lane, or clear after a closing beat.
    always_comb begin
        idx_d     = idx_q;
        asm_dat_d = asm_dat_q;
        asm_ben_d = asm_ben_q;
        if (accept_s) begin
            if (close_s) begin
                idx_d     = {IDXW{1'b0}};
                asm_dat_d = {DATA_W{1'b0}};
                asm_ben_d = {NB{1'b0}};
            end else begin
                idx_d     = idx_q + IDXW'(1);
                asm_dat_d = merged_dat_s;
                asm_ben_d = merged_ben_s;
            end
        end else begin
            idx_d     = idx_q;
            asm_dat_d = asm_dat_q;
            asm_ben_d = asm_ben_q;
        end
    end

    // FIFO next state: push a closed word at the tail, pop the head.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int e = 0; e < DEPTH; e++) begin
            mem_d[e] = mem_q[e];
        end
        if (push_s) begin
            mem_d[wr_ptr_q[PW-1:0]] = {merged_ben_s, merged_dat_s};
            wr_ptr_d                = wr_ptr_q + (PW+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // State registers; reset discards the partial word and all queued words.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idx_q     <= {IDXW{1'b0}};
            asm_dat_q <= {DATA_W{1'b0}};
            asm_ben_q <= {NB{1'b0}};
            wr_ptr_q  <= {(PW+1){1'b0}};
            rd_ptr_q  <= {(PW+1){1'b0}};
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= {OW{1'b0}};
            end
        end else begin
            idx_q     <= idx_d;
            asm_dat_q <= asm_dat_d;
            asm_ben_q <= asm_ben_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= mem_d[e];
            end
        end
    end

endmodule

// File: tb/tb_vxe_txnreqd_packer.sv
// Bench for vxe_txnreqd_packer: a 64-bit/2-lane instance and a 128-bit/4-lane
// instance share the beat inputs; a word-level queue model predicts outputs.
module tb_vxe_txnreqd_packer;

    localparam int DEPTH = 2;

    logic         clk;
    logic         nrst;
    logic         i_vld;
    logic         i_last;
    logic         i_rdy;
    logic [31:0]  i_data;
    logic [3:0]   i_ben;

    logic         a_rdy, a_vld, a_busy;
    logic [71:0]  a_dat;
    logic         b_rdy, b_vld, b_busy;
    logic [143:0] b_dat;

    bit           sel;        // 0: observe 64/2 instance, 1: observe 128/4 instance
    logic         obs_rdy, obs_vld, obs_busy;
    logic [143:0] obs_dat;

    int tests = 0;
    int fails = 0;

    // Reference model: queue of complete words plus the word under assembly.
    logic [143:0] exp_q[$];
    logic [127:0] cur_dat;
    logic [15:0]  cur_ben;
    int           lane;
    int           n_pop;

    vxe_txnreqd_packer #(.DATA_W(64), .LANES(2), .DEPTH(DEPTH)) dut_a (
        .clk(clk), .nrst(nrst), .i_vld(i_vld), .o_rdy(a_rdy), .i_data(i_data),
        .i_ben(i_ben), .i_last(i_last), .o_vld(a_vld), .i_rdy(i_rdy),
        .o_req_vec_dat(a_dat), .o_busy(a_busy)
    );

    vxe_txnreqd_packer #(.DATA_W(128), .LANES(4), .DEPTH(DEPTH)) dut_b (
        .clk(clk), .nrst(nrst), .i_vld(i_vld), .o_rdy(b_rdy), .i_data(i_data),
        .i_ben(i_ben), .i_last(i_last), .o_vld(b_vld), .i_rdy(i_rdy),
        .o_req_vec_dat(b_dat), .o_busy(b_busy)
    );

    assign obs_rdy  = sel ? b_rdy  : a_rdy;
    assign obs_vld  = sel ? b_vld  : a_vld;
    assign obs_busy = sel ? b_busy : a_busy;
    assign obs_dat  = sel ? b_dat  : {72'd0, a_dat};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [143:0] fmt_word();
        if (sel) return {cur_ben, cur_dat};
        else     return {72'd0, cur_ben[7:0], cur_dat[63:0]};
    endfunction

    task automatic model_clear();
        exp_q.delete();
        cur_dat = '0;
        cur_ben = '0;
        lane    = 0;
    endtask

    task automatic do_reset();
        nrst = 1'b0; i_vld = 1'b0; i_last = 1'b0; i_rdy = 1'b0;
        i_data = 32'd0; i_ben = 4'd0;
        repeat (2) @(posedge clk);
        #3 nrst = 1'b1;
        model_clear();
        @(posedge clk); #1;
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model.
    task automatic step(output bit acc);
        bit ev, er, eb;
        logic [143:0] w;
        int lanes;
        lanes = sel ? 4 : 2;
        @(negedge clk);
        ev = (exp_q.size() != 0);
        er = (exp_q.size() < DEPTH);
        eb = (lane != 0) || ev;
        tests++;
        if (obs_vld !== ev) begin
            fails++; $display("FAIL o_vld t=%0t got %b exp %b", $time, obs_vld, ev);
        end
        tests++;
        if (obs_rdy !== er) begin
            fails++; $display("FAIL o_rdy t=%0t got %b exp %b", $time, obs_rdy, er);
        end
        tests++;
        if (obs_busy !== eb) begin
            fails++; $display("FAIL o_busy t=%0t got %b exp %b", $time, obs_busy, eb);
        end
        if (ev) begin
            tests++;
            if (obs_dat !== exp_q[0]) begin
                fails++; $display("FAIL head_word t=%0t got %h exp %h", $time, obs_dat, exp_q[0]);
            end
        end
        acc = i_vld && er;
        if (ev && i_rdy) begin
            w = exp_q.pop_front();
            n_pop++;
        end
        if (acc) begin
            cur_dat[lane*32 +: 32] = i_data;
            cur_ben[lane*4 +: 4]   = i_ben;
            if (lane == lanes - 1 || i_last) begin
                exp_q.push_back(fmt_word());
                cur_dat = '0; cur_ben = '0; lane = 0;
            end else begin
                lane++;
            end
        end
        @(posedge clk); #1;
    endtask

    // Present a beat and hold it until accepted (bounded).
    task automatic send(input logic [31:0] d, input logic [3:0] b, input logic l, input bit toggle);
        bit acc;
        int n;
        i_vld = 1'b1; i_data = d; i_ben = b; i_last = l;
        acc = 1'b0; n = 0;
        while (!acc && n < 50) begin
            step(acc);
            n++;
            if (toggle) i_rdy = !i_rdy;
        end
        tests++;
        if (!acc) begin
            fails++; $display("FAIL send_timeout data %h not accepted in 50 cycles", d);
        end
        i_vld = 1'b0; i_last = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n;
        i_vld = 1'b0; i_rdy = 1'b1; n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            step(acc);
            n++;
        end
        step(acc);
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL drain_timeout %0d words left", exp_q.size());
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        tests++;
        if (a_rdy !== 1'b1 || a_vld !== 1'b0 || a_busy !== 1'b0) begin
            fails++; $display("FAIL reset_flags got rdy=%b vld=%b busy=%b exp 1 0 0", a_rdy, a_vld, a_busy);
        end
        tests++;
        if (a_dat !== 72'h0) begin
            fails++; $display("FAIL reset_data got %h exp 0", a_dat);
        end
        tests++;
        if (b_dat !== 144'h0 || b_vld !== 1'b0) begin
            fails++; $display("FAIL reset_b got vld=%b data=%h exp 0", b_vld, b_dat);
        end
    endtask

    task automatic test_full_word();
        sel = 1'b0; i_rdy = 1'b1;
        send(32'h11223344, 4'hF, 1'b0, 1'b0);
        send(32'hAABBCCDD, 4'h3, 1'b0, 1'b0);
        tests++;
        if (a_vld !== 1'b1 || a_dat !== 72'h3F_AABBCCDD_11223344) begin
            fails++; $display("FAIL full_word got vld=%b %h exp 1 3faabbccdd11223344", a_vld, a_dat);
        end
        drain();
        tests++;
        if (a_busy !== 1'b0) begin
            fails++; $display("FAIL full_word_busy got %b exp 0", a_busy);
        end
    endtask

    task automatic test_partial();
        sel = 1'b0; i_rdy = 1'b1;
        send(32'hDEADBEEF, 4'h5, 1'b1, 1'b0);
        tests++;
        if (a_vld !== 1'b1 || a_dat !== 72'h05_00000000_DEADBEEF) begin
            fails++; $display("FAIL partial got vld=%b %h exp 1 0500000000deadbeef", a_vld, a_dat);
        end
        drain();
        send(32'h12345678, 4'hF, 1'b1, 1'b0);
        tests++;
        if (a_dat !== 72'h0F_00000000_12345678) begin
            fails++; $display("FAIL partial_lane0 got %h exp 0f0000000012345678", a_dat);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] d [6];
        logic [3:0]  b [6];
        logic [71:0] w1;
        bit acc;
        int pops0;
        sel = 1'b0; i_rdy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            d[k] = $urandom;
            b[k] = 4'($urandom_range(0, 15));
        end
        w1 = {b[1], b[0], d[1], d[0]};
        pops0 = n_pop;
        for (int k = 0; k < 4; k++) send(d[k], b[k], 1'b0, 1'b0);
        tests++;
        if (a_rdy !== 1'b0) begin
            fails++; $display("FAIL bp_full_rdy got %b exp 0", a_rdy);
        end
        i_vld = 1'b1; i_data = d[4]; i_ben = b[4]; i_last = 1'b0;
        repeat (3) begin
            step(acc);
            tests++;
            if (a_rdy !== 1'b0 || a_dat !== w1) begin
                fails++; $display("FAIL bp_hold got rdy=%b %h exp 0 %h", a_rdy, a_dat, w1);
            end
        end
        i_rdy = 1'b1;
        send(d[4], b[4], 1'b0, 1'b0);
        send(d[5], b[5], 1'b0, 1'b0);
        drain();
        tests++;
        if (n_pop - pops0 != 3) begin
            fails++; $display("FAIL bp_count got %0d words exp 3", n_pop - pops0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d0, d1;
        bit acc;
        sel = 1'b0;
        do_reset();
        i_rdy = 1'b0;
        send(32'h01020304, 4'hF, 1'b0, 1'b0);
        send(32'h05060708, 4'hF, 1'b0, 1'b0);
        send(32'h0A0B0C0D, 4'hF, 1'b0, 1'b0);
        #2 nrst = 1'b0;
        #1;
        tests++;
        if (a_vld !== 1'b0 || a_busy !== 1'b0 || a_rdy !== 1'b1) begin
            fails++; $display("FAIL reset_mid got vld=%b busy=%b rdy=%b exp 0 0 1", a_vld, a_busy, a_rdy);
        end
        model_clear();
        @(posedge clk); #2 nrst = 1'b1;
        i_rdy = 1'b1;
        repeat (4) step(acc);
        d0 = $urandom; d1 = $urandom;
        send(d0, 4'hC, 1'b0, 1'b0);
        send(d1, 4'h9, 1'b0, 1'b0);
        tests++;
        if (a_vld !== 1'b1 || a_dat !== {4'h9, 4'hC, d1, d0}) begin
            fails++; $display("FAIL reset_mid_word got vld=%b %h exp 1 %h", a_vld, a_dat, {4'h9, 4'hC, d1, d0});
        end
        drain();
    endtask

    task automatic test_wrap();
        int nl, words, pops0;
        sel = 1'b1;
        do_reset();
        i_rdy = 1'b1;
        pops0 = n_pop;
        words = 20;
        for (int w = 0; w < words; w++) begin
            nl = $urandom_range(1, 4);
            for (int l = 0; l < nl; l++) begin
                send($urandom, 4'($urandom_range(0, 15)), (l == nl - 1) ? 1'b1 : 1'b0, 1'b1);
            end
        end
        drain();
        tests++;
        if (n_pop - pops0 != words) begin
            fails++; $display("FAIL wrap_count got %0d words exp %0d", n_pop - pops0, words);
        end
    endtask

    initial begin
        n_pop = 0;
        model_clear();
        test_reset();
        test_full_word();
        test_partial();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
